// File: rtl/mmr_noc_sched.sv
// ---------------------------------------------------------------------------
// mmr_noc_sched
//
// Owns the write port of the five-entry MMR file at BASE_ADDR..BASE_ADDR+0x13
// and sequences NoC transfers.
//   entry 0..3 : loadnoc words, mirrored here in shadow registers
//   entry 4    : storenoc trigger (bit 0) and completion status
//
// A CPU store that hits the window while idle is forwarded to the MMR file
// one cycle later. A store to entry 4 with bit 0 set starts a transfer:
// the four shadow words are streamed to the NoC, the response is awaited
// (bounded by TIMEOUT cycles), and a status word is written back to entry 4.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   cpu_we/addr/wdata     writeback store request
//   cpu_stall             window hit refused while a transfer is in flight
//   mmr_we/location       registered MMR write port (enable, byte address)
//   loadnoc_data_from_wb  registered MMR write data
//   noc_valid/data/last   outbound word stream, last marks word 3
//   noc_ready             NoC accepts the current word
//   noc_resp_valid/status single-cycle response strobe and code
//   busy                  sequencer not idle
//   dbg_state             current sequencer state (debug observation)
//
// Handshake: a word transfers on a rising edge where noc_valid and
// noc_ready are both high. Once noc_valid rises, it and noc_data/noc_last
// stay unchanged until that edge; noc_ready may toggle freely.
// ---------------------------------------------------------------------------
module mmr_noc_sched #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        mmr_we,
  output logic [31:0] mmr_location,
  output logic [31:0] loadnoc_data_from_wb,
  output logic        noc_valid,
  output logic [31:0] noc_data,
  output logic        noc_last,
  input  logic        noc_ready,
  input  logic        noc_resp_valid,
  input  logic [7:0]  noc_resp_status,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_STATUS    = 2'd3
  } state_t;

  // The timer counts WAIT_RESP edges starting from 0, so the edge that
  // completes TIMEOUT cycles sees the timer at TIMEOUT-1.
  localparam logic [7:0]  TIMER_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'h10;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [7:0]  r_timer;
  logic        r_mmr_we;
  logic [31:0] r_mmr_loc;
  logic [31:0] r_mmr_data;
  logic [31:0] r_shadow [4];

  state_t      w_state_nxt;
  logic [1:0]  w_cnt_nxt;
  logic [7:0]  w_timer_nxt;
  logic        w_we_nxt;
  logic [31:0] w_loc_nxt;
  logic [31:0] w_data_nxt;
  logic        w_hit;
  logic        w_accept;
  logic [2:0]  w_idx;
  logic        w_shadow_we;
  logic [7:0]  w_resp_code;
  logic        w_resp_err;

  // Window decode: word-aligned, inside the page, entries 0..4 only.
  assign w_hit = cpu_we
              && (cpu_addr[31:8] == BASE_ADDR[31:8])
              && (cpu_addr[1:0] == 2'b00)
              && (cpu_addr[7:2] <= 6'd4);
  assign w_idx       = cpu_addr[4:2];
  assign w_accept    = w_hit && (r_state == ST_IDLE);
  assign w_shadow_we = w_accept && !w_idx[2];

  assign cpu_stall = w_hit && (r_state != ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

  assign noc_valid = (r_state == ST_SEND);
  assign noc_data  = noc_valid ? r_shadow[r_cnt] : 32'h0;
  assign noc_last  = noc_valid && (r_cnt == 2'd3);

  assign mmr_we               = r_mmr_we;
  assign mmr_location         = r_mmr_loc;
  assign loadnoc_data_from_wb = r_mmr_data;

  // A response on the timeout edge wins over the timeout.
  always_comb begin
    w_resp_code = 8'hFF;
    w_resp_err  = 1'b1;
    if (noc_resp_valid) begin
      w_resp_code = noc_resp_status;
      w_resp_err  = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    w_we_nxt    = 1'b0;
    w_loc_nxt   = r_mmr_loc;
    w_data_nxt  = r_mmr_data;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_we_nxt   = 1'b1;
          w_loc_nxt  = cpu_addr;
          w_data_nxt = cpu_wdata;
          if (w_idx == 3'd4 && cpu_wdata[0]) begin
            w_state_nxt = ST_SEND;
            w_cnt_nxt   = 2'd0;
          end
        end
      end
      ST_SEND: begin
        if (noc_ready) begin
          if (r_cnt == 2'd3) begin
            w_state_nxt = ST_WAIT_RESP;
            w_cnt_nxt   = 2'd0;
            w_timer_nxt = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      ST_WAIT_RESP: begin
        if (noc_resp_valid || r_timer == TIMER_LAST) begin
          // The status write is registered on the way into STATUS so the
          // write port carries it during the single STATUS cycle.
          w_state_nxt = ST_STATUS;
          w_we_nxt    = 1'b1;
          w_loc_nxt   = STATUS_ADDR;
          w_data_nxt  = {16'h0, w_resp_code, 5'h0, w_resp_err, 1'b1, 1'b0};
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      ST_STATUS: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 2'd0;
      r_timer    <= 8'd0;
      r_mmr_we   <= 1'b0;
      r_mmr_loc  <= 32'h0;
      r_mmr_data <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_mmr_we   <= w_we_nxt;
      r_mmr_loc  <= w_loc_nxt;
      r_mmr_data <= w_data_nxt;
    end
  end

  // Shadows only change on accepted stores, which cannot happen mid-transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_shadow[i] <= 32'h0;
    end else if (w_shadow_we) begin
      r_shadow[w_idx[1:0]] <= cpu_wdata;
    end
  end

endmodule
